reg_bank_write_arbiter: RTL and testbench

//  Shares the single write port (WE3/A3/WD3) of the 16-entry register bank between NREQ requesters
//  (default: scalar ALU, vector unit, memory load return). Round-robin arbitration, valid/ready handshake,

---
 rtl/reg_arb_pkg.sv | 18 +
 rtl/reg_bank_write_arbiter_if.sv | 35 +++
 rtl/reg_bank_write_arbiter_picker.sv | 49 ++++
 rtl/reg_bank_write_arbiter.sv | 113 +++++++++++
 tb/tb_reg_bank_write_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_arb_pkg.sv
// Shared definitions for the register-bank write arbiter: address widths,
// the protected register index and the debug counter type.
package reg_arb_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int NUM_REGS   = 16;
  localparam int WR_COUNT_W = 16;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [WR_COUNT_W-1:0] wr_count_t;

  localparam reg_addr_t REG_ZERO = 4'd0;

  function automatic logic is_reg_zero(input reg_addr_t addr);
    return addr == REG_ZERO;
  endfunction

endpackage

// File: rtl/reg_bank_write_arbiter_if.sv
// Write-request bus between the execute/writeback producers (master) and the
// register-bank write arbiter (slave), including the registered bank-side port.
interface reg_bank_write_arbiter_if
  import reg_arb_pkg::*;
#(
  parameter int BITS = 32,
  parameter int NREQ = 3
);

  localparam int IDX_W = $clog2(NREQ);

  logic                          stall;
  logic [NREQ-1:0]               req_valid;
  logic [NREQ*REG_ADDR_W-1:0]    req_addr;
  logic [NREQ*BITS-1:0]          req_data;
  logic [NREQ-1:0]               req_ready;

  logic                          we3;
  reg_addr_t                     a3;
  logic [BITS-1:0]               wd3;
  logic [IDX_W-1:0]              grant_id;
  logic                          drop_r0;
  wr_count_t                     wr_count;

  modport master (
    output stall, req_valid, req_addr, req_data,
    input  req_ready, we3, a3, wd3, grant_id, drop_r0, wr_count
  );

  modport slave (
    input  stall, req_valid, req_addr, req_data,
    output req_ready, we3, a3, wd3, grant_id, drop_r0, wr_count
  );

endinterface

// File: rtl/reg_bank_write_arbiter_picker.sv
// Purely combinational rotating-priority picker: the first asserted request
// at or after ptr_i (wrapping modulo N) wins.
module rr_priority_picker #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o,
  output logic          any_o
);

  localparam int SW = IW + 1;

  logic [N-1:0]  rot_req;
  logic [IW-1:0] first_off;
  logic          found;
  logic [SW-1:0] idx_sum;

  // Rotate so that bit k corresponds to requester (ptr + k) mod N.
  assign rot_req = N'({req_i, req_i} >> ptr_i);
  assign any_o   = |req_i;

  always_comb begin
    first_off = '0;
    found     = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot_req[k]) begin
        found     = 1'b1;
        first_off = IW'(k);
      end
    end
  end

  always_comb begin
    idx_sum = {1'b0, ptr_i} + {1'b0, first_off};
    if (idx_sum >= SW'(N)) begin
      idx_sum = idx_sum - SW'(N);
    end
  end

  assign grant_idx_o = idx_sum[IW-1:0];

  for (genvar gi = 0; gi < N; gi++) begin : g_onehot
    assign grant_o[gi] = any_o && (grant_idx_o == IW'(gi));
  end

endmodule

// File: rtl/reg_bank_write_arbiter.sv
// Round-robin arbiter sharing the single register-bank write port among NREQ
// requesters, with a registered commit stage, R0 protection and a commit counter.
module reg_bank_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int BITS       = 32,
  parameter int NREQ       = 3,
  parameter bit PROTECT_R0 = 1'b1
) (
  input logic                     clk,
  input logic                     rst,
  reg_bank_write_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NREQ);
  typedef logic [IDX_W-1:0] idx_t;

  idx_t            ptr_q, ptr_d;
  logic            we3_q, we3_d;
  reg_addr_t       a3_q, a3_d;
  logic [BITS-1:0] wd3_q, wd3_d;
  idx_t            gid_q, gid_d;
  logic            drop_q, drop_d;
  wr_count_t       cnt_q, cnt_d;

  logic [NREQ-1:0] win_onehot;
  idx_t            win_idx;
  logic            win_any;
  logic            transfer;

  reg_addr_t       addr_arr [NREQ];
  logic [BITS-1:0] data_arr [NREQ];
  reg_addr_t       addr_sel;
  logic [BITS-1:0] data_sel;

  rr_priority_picker #(.N(NREQ)) u_picker (
    .req_i       (bus.req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (win_onehot),
    .grant_idx_o (win_idx),
    .any_o       (win_any)
  );

  // A valid winner is always granted unless stalled or in reset, so grant implies transfer.
  assign transfer      = win_any && !bus.stall && !rst;
  assign bus.req_ready = transfer ? win_onehot : '0;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign addr_arr[gi] = bus.req_addr[gi*REG_ADDR_W +: REG_ADDR_W];
    assign data_arr[gi] = bus.req_data[gi*BITS +: BITS];
  end

  always_comb begin
    addr_sel = '0;
    data_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_onehot[i]) begin
        addr_sel = addr_sel | addr_arr[i];
        data_sel = data_sel | data_arr[i];
      end
    end
  end

  always_comb begin
    ptr_d  = ptr_q;
    a3_d   = a3_q;
    wd3_d  = wd3_q;
    gid_d  = gid_q;
    we3_d  = 1'b0;
    drop_d = 1'b0;
    cnt_d  = cnt_q + wr_count_t'(we3_q);
    if (transfer) begin
      ptr_d = (win_idx == idx_t'(NREQ - 1)) ? '0 : win_idx + 1'b1;
      a3_d  = addr_sel;
      wd3_d = data_sel;
      gid_d = win_idx;
      // R0 writes complete the handshake but never reach the bank.
      if (PROTECT_R0 && is_reg_zero(addr_sel)) begin
        drop_d = 1'b1;
      end else begin
        we3_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= '0;
      we3_q  <= 1'b0;
      a3_q   <= '0;
      wd3_q  <= '0;
      gid_q  <= '0;
      drop_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      we3_q  <= we3_d;
      a3_q   <= a3_d;
      wd3_q  <= wd3_d;
      gid_q  <= gid_d;
      drop_q <= drop_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.we3      = we3_q;
  assign bus.a3       = a3_q;
  assign bus.wd3      = wd3_q;
  assign bus.grant_id = gid_q;
  assign bus.drop_r0  = drop_q;
  assign bus.wr_count = cnt_q;

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Scoreboard bench for reg_bank_write_arbiter: directed scenarios plus random
// traffic, with a round-robin reference model predicting every commit.
module tb_reg_bank_write_arbiter;
  import reg_arb_pkg::*;

  localparam int BITS  = 32;
  localparam int NREQ  = 3;
  localparam bit PROT  = 1'b1;

  typedef struct {
    logic            we;
    logic            drop;
    logic [3:0]      addr;
    logic [BITS-1:0] data;
    int              gid;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  reg_bank_write_arbiter_if #(.BITS(BITS), .NREQ(NREQ)) bus ();

  reg_bank_write_arbiter #(.BITS(BITS), .NREQ(NREQ), .PROTECT_R0(PROT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t            exp_q[$];
  int              checks = 0;
  int              failures = 0;
  int              ptr_m = 0;
  logic [15:0]     cnt_m = '0;
  logic [15:0]     we_pushed = '0;
  bit              mon_en = 1'b0;
  bit              quiet = 1'b0;
  logic [BITS-1:0] shadow [NUM_REGS];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Drive one cycle of requests at the falling edge and predict the outcome.
  task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*4-1:0] a,
                      input logic [NREQ*BITS-1:0] d, input logic st, output int w);
    exp_t e;
    logic [NREQ-1:0] rdy_exp;
    @(negedge clk);
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.req_data  = d;
    bus.stall     = st;
    #1;
    w = -1;
    rdy_exp = '0;
    if (!st) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (ptr_m + k) % NREQ;
        if (w < 0 && v[i]) w = i;
      end
    end
    if (w >= 0) begin
      rdy_exp[w] = 1'b1;
      e.addr = a[4*w +: 4];
      e.data = d[BITS*w +: BITS];
      e.gid  = w;
      e.drop = PROT && (e.addr == 4'd0);
      e.we   = !e.drop;
      exp_q.push_back(e);
      if (e.we) we_pushed++;
      ptr_m = (w + 1) % NREQ;
    end
    check("req_ready", 64'(bus.req_ready), 64'(rdy_exp));
  endtask

  task automatic idle(output int w);
    step('0, '0, '0, 1'b0, w);
  endtask

  always @(posedge clk) begin
    if (bus.we3) shadow[bus.a3] <= bus.wd3;
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        check("wr_count", 64'(bus.wr_count), 64'(cnt_m));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("we3", 64'(bus.we3), 64'(e.we));
          check("drop_r0", 64'(bus.drop_r0), 64'(e.drop));
          check("a3", 64'(bus.a3), 64'(e.addr));
          check("wd3", 64'(bus.wd3), 64'(e.data));
          check("grant_id", 64'(bus.grant_id), 64'(e.gid));
          if (e.we) cnt_m++;
          if (!quiet)
            $display("commit gid=%0d a3=%0d wd3=%h we3=%0b drop=%0b count=%0d",
                     bus.grant_id, bus.a3, bus.wd3, bus.we3, bus.drop_r0, bus.wr_count);
        end else begin
          check("we3_idle", 64'(bus.we3), 64'd0);
          check("drop_idle", 64'(bus.drop_r0), 64'd0);
        end
      end
    end
  end

  initial begin : stimulus
    int w;
    int rem;
    logic [NREQ-1:0]      pv;
    logic [NREQ*4-1:0]    pa;
    logic [NREQ*BITS-1:0] pd;
    logic                 st;

    for (int i = 0; i < NUM_REGS; i++) shadow[i] = '0;
    bus.stall     = 1'b0;
    bus.req_valid = '1;
    bus.req_addr  = {4'd3, 4'd2, 4'd1};
    bus.req_data  = '1;

    // Reset state, with all requesters valid
    #1;
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    check("rst_we3", 64'(bus.we3), 64'd0);
    check("rst_a3", 64'(bus.a3), 64'd0);
    check("rst_wd3", 64'(bus.wd3), 64'd0);
    check("rst_gid", 64'(bus.grant_id), 64'd0);
    check("rst_drop", 64'(bus.drop_r0), 64'd0);
    check("rst_count", 64'(bus.wr_count), 64'd0);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // Round robin with all three valid
    repeat (6) step(3'b111, {4'd3, 4'd2, 4'd1}, {32'h33, 32'h22, 32'h11}, 1'b0, w);
    idle(w);
    idle(w);
    check("rr_count", 64'(bus.wr_count), 64'd6);

    // R0 protection
    step(3'b001, {4'd0, 4'd0, 4'd0}, {32'h0, 32'h0, 32'hDEAD}, 1'b0, w);
    idle(w);
    check("r0_drop", 64'(bus.drop_r0), 64'd1);
    check("r0_we3", 64'(bus.we3), 64'd0);
    idle(w);
    check("r0_count", 64'(bus.wr_count), 64'd6);

    // Bring the pointer back to 0, then same-address collision
    step(3'b100, {4'd9, 4'd0, 4'd0}, {32'h99, 32'h0, 32'h0}, 1'b0, w);
    step(3'b101, {4'd5, 4'd0, 4'd5}, {32'h22, 32'h0, 32'h11}, 1'b0, w);
    step(3'b100, {4'd5, 4'd0, 4'd5}, {32'h22, 32'h0, 32'h11}, 1'b0, w);
    idle(w);
    idle(w);
    check("collision_r5", 64'(shadow[5]), 64'h22);
    check("collision_count", 64'(bus.wr_count), 64'd9);

    // Stall with a commit still in flight
    step(3'b001, {4'd0, 4'd0, 4'd4}, {32'h0, 32'h0, 32'h44}, 1'b0, w);
    repeat (3) step(3'b010, {4'd0, 4'd6, 4'd0}, {32'h0, 32'h66, 32'h0}, 1'b1, w);
    check("stall_we3", 64'(bus.we3), 64'd0);
    step(3'b010, {4'd0, 4'd6, 4'd0}, {32'h0, 32'h66, 32'h0}, 1'b0, w);
    idle(w);
    idle(w);
    check("stall_r4", 64'(shadow[4]), 64'h44);
    check("stall_r6", 64'(shadow[6]), 64'h66);

    // Random traffic obeying the hold-until-transfer rule
    pv = '0;
    pa = '0;
    pd = '0;
    repeat (400) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pv[i] && ($urandom_range(0, 1) == 1)) begin
          pv[i] = 1'b1;
          pa[4*i +: 4] = 4'($urandom_range(0, 15));
          pd[BITS*i +: BITS] = $urandom;
        end
      end
      st = ($urandom_range(0, 5) == 0);
      step(pv, pa, pd, st, w);
      if (w >= 0) pv[w] = 1'b0;
    end
    idle(w);
    idle(w);

    // Counter wrap: bring the count to 16'hFFFF, then one more commit
    quiet = 1'b1;
    rem = int'(16'hFFFF - we_pushed);
    for (int i = 0; i < rem; i++) begin
      step(3'b001, {4'd0, 4'd0, 4'd7}, {32'h0, 32'h0, 32'(i)}, 1'b0, w);
    end
    idle(w);
    idle(w);
    quiet = 1'b0;
    check("wrap_full", 64'(bus.wr_count), 64'hFFFF);
    step(3'b001, {4'd0, 4'd0, 4'd8}, {32'h0, 32'h0, 32'hABCD}, 1'b0, w);
    idle(w);
    check("wrap_we3", 64'(bus.we3), 64'd1);
    check("wrap_pre", 64'(bus.wr_count), 64'hFFFF);
    idle(w);
    check("wrap_zero", 64'(bus.wr_count), 64'd0);

    // Reset mid-operation while a commit is in flight
    @(negedge clk);
    mon_en = 1'b0;
    bus.req_valid = 3'b111;
    bus.req_addr  = {4'd3, 4'd2, 4'd1};
    bus.req_data  = {32'hC3, 32'hC2, 32'hC1};
    bus.stall     = 1'b0;
    @(posedge clk);
    #2;
    check("pre_rst_we3", 64'(bus.we3), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_we3", 64'(bus.we3), 64'd0);
    check("midrst_a3", 64'(bus.a3), 64'd0);
    check("midrst_wd3", 64'(bus.wd3), 64'd0);
    check("midrst_count", 64'(bus.wr_count), 64'd0);
    check("midrst_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk);
    bus.req_valid = '0;
    rst = 1'b0;
    exp_q.delete();
    ptr_m = 0;
    cnt_m = '0;
    we_pushed = '0;
    mon_en = 1'b1;

    // Pointer restarts at 0 after reset
    step(3'b111, {4'd3, 4'd2, 4'd1}, {32'hD3, 32'hD2, 32'hD1}, 1'b0, w);
    step(3'b110, {4'd3, 4'd2, 4'd1}, {32'hD3, 32'hD2, 32'hD1}, 1'b0, w);
    idle(w);
    idle(w);
    check("post_rst_count", 64'(bus.wr_count), 64'd2);
    check("post_rst_r1", 64'(shadow[1]), 64'hD1);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
